alu_spi_master: RTL and testbench



---
 rtl/alu_spi_master_if.sv | 30 +++
 rtl/alu_spi_master.sv | 141 ++++++++++++++
 tb/tb_alu_spi_master.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_spi_master_if.sv
// ALU link types and the shared Spi bus (nss active-low selects, mosi, miso).
// MasterSpi drives nss/mosi and samples miso; SlaveSpi is the mirror view.
package alu_spi_pkg;
  localparam int REGISTER_SIZE = 8;
  localparam int NSS_WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } Operation;

  typedef struct packed {
    logic [REGISTER_SIZE-1:0] op_2;
    logic [REGISTER_SIZE-1:0] op_1;
    Operation                 op_code;
  } AluPacket;
endpackage

interface Spi;
  import alu_spi_pkg::*;
  logic [NSS_WIDTH-1:0] nss;
  logic                 mosi;
  logic                 miso;

  modport MasterSpi (output nss, output mosi, input miso);
  modport SlaveSpi (input nss, input mosi, output miso);
endinterface

// File: rtl/alu_spi_master.sv
// SPI master for the ALU link: sends {op_2, op_1, op_code} LSB first,
// waits for the slave send flag, receives the result LSB first.
module alu_spi_master
  import alu_spi_pkg::*;
#(
  parameter int NssPosition = 0,
  parameter int TimeoutCycles = 16
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  Operation                 i_op_code,
  input  logic [REGISTER_SIZE-1:0] i_op_1,
  input  logic [REGISTER_SIZE-1:0] i_op_2,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [REGISTER_SIZE-1:0] o_result,
  output logic                     o_error,
  Spi.MasterSpi                    spi
);
  localparam int P = $bits(AluPacket);
  localparam int R = REGISTER_SIZE;
  localparam int CntMax = (P > TimeoutCycles) ? P : TimeoutCycles;
  localparam int CntW = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TRANSMIT,
    S_WAIT,
    S_RECEIVE,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [P-1:0]    tx_q, tx_d;
  logic [R-1:0]    rx_q, rx_d;
  logic [R-1:0]    result_q, result_d;
  logic            error_q, error_d;
  logic            sel;
  logic            mosi;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      result_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      result_q   <= result_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    result_d   = result_q;
    error_d    = 1'b0;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    sel        = 1'b0;
    mosi       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_valid) begin
          tx_d    = {i_op_2, i_op_1, i_op_code};
          state_d = S_START;
        end
      end
      S_START: begin
        sel       = 1'b1;
        mosi      = 1'b1;
        bit_cnt_d = '0;
        state_d   = S_TRANSMIT;
      end
      S_TRANSMIT: begin
        sel  = 1'b1;
        mosi = tx_q[0];
        tx_d = tx_q >> 1;
        if (bit_cnt_q == CntW'(P - 1)) begin
          bit_cnt_d  = '0;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      S_WAIT: begin
        sel = 1'b1;
        // only a clean 1 is a send flag; x/z compare false
        if (spi.miso == 1'b1) begin
          bit_cnt_d = '0;
          state_d   = S_RECEIVE;
        end else if (wait_cnt_q == CntW'(TimeoutCycles - 1)) begin
          wait_cnt_d = '0;
          error_d    = 1'b1;
          state_d    = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      S_RECEIVE: begin
        sel  = 1'b1;
        // LSB arrives first, so after R shifts it sits at bit 0
        rx_d = {spi.miso, rx_q[R-1:1]};
        if (bit_cnt_q == CntW'(R - 1)) begin
          bit_cnt_d = '0;
          result_d  = rx_d;
          state_d   = S_DONE;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      S_DONE: begin
        o_valid = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign spi.nss  = sel ? ~(NSS_WIDTH'(1) << NssPosition) : '1;
  assign spi.mosi = mosi;
  assign o_result = result_q;
  assign o_error  = error_q;
endmodule

// File: tb/tb_alu_spi_master.sv
// Bench for alu_spi_master with a behavioural ALU slave on the Spi bus.
// Randomised and directed transactions checked against an ALU reference.
module tb_alu_spi_master;
  import alu_spi_pkg::*;

  localparam int POS = 2;
  localparam int TO  = 16;
  localparam int NW  = NSS_WIDTH;
  localparam int R   = REGISTER_SIZE;
  localparam int P   = $bits(AluPacket);
  localparam int LAT = P + R + 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  Operation      op;
  logic [R-1:0]  a, b;
  logic          rdy, ov, err;
  logic [R-1:0]  res;
  int            total = 0;
  int            bad = 0;
  bit            slave_en = 1'b1;
  int            sl_ph = 0;
  logic [P-1:0]  sl_pkt = '0;
  logic [R-1:0]  sl_res = '0;
  logic [NW-1:0] sel_mask, idle_mask;

  Spi bus();

  always #5 clk = ~clk;

  alu_spi_master #(.NssPosition(POS), .TimeoutCycles(TO)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_valid(valid),
    .i_op_code(op),
    .i_op_1(a),
    .i_op_2(b),
    .o_ready(rdy),
    .o_valid(ov),
    .o_result(res),
    .o_error(err),
    .spi(bus)
  );

  function automatic logic [R-1:0] alu_ref(input logic [2:0] o,
                                           input logic [R-1:0] x,
                                           input logic [R-1:0] y);
    case (o)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      default: return '0;
    endcase
  endfunction

  // ALU slave: start bit, P packet bits, one operate cycle,
  // send flag, then R result bits; values change on negedge.
  always @(negedge clk) begin
    if (!rst_n || !slave_en) begin
      sl_ph = 0;
      bus.miso = 1'b0;
    end else if (sl_ph == 0) begin
      bus.miso = 1'b0;
      if (bus.nss[POS] == 1'b0 && bus.mosi == 1'b1) begin
        sl_ph = 1;
        sl_pkt = '0;
      end
    end else if (sl_ph <= P) begin
      sl_pkt[sl_ph-1] = bus.mosi;
      sl_ph++;
      if (sl_ph == P + 1)
        sl_res = alu_ref(sl_pkt[2:0], sl_pkt[3 +: R], sl_pkt[3+R +: R]);
    end else if (sl_ph == P + 1) begin
      bus.miso = 1'b0;
      sl_ph++;
    end else if (sl_ph == P + 2) begin
      bus.miso = 1'b1;
      sl_ph++;
    end else if (sl_ph < P + 3 + R) begin
      bus.miso = sl_res[sl_ph-P-3];
      sl_ph++;
    end else begin
      bus.miso = 1'b0;
      sl_ph = 0;
    end
  end

  task automatic accept(input logic [2:0] o, input logic [R-1:0] x,
                        input logic [R-1:0] y);
    @(negedge clk);
    total++;
    if (rdy !== 1'b1) begin
      bad++;
      $display("FAIL ready_idle got=%0b want=1", rdy);
    end
    valid = 1'b1;
    op = Operation'(o);
    a = x;
    b = y;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [R-1:0] x,
                        input logic [R-1:0] y, input bit scramble,
                        input string name);
    logic [R-1:0] exp_res, got;
    logic [P-1:0] exp_pkt;
    int vcyc, nvalid, nss_bad, err_bad;
    exp_res = alu_ref(o, x, y);
    exp_pkt = {y, x, o};
    vcyc = -1;
    nvalid = 0;
    nss_bad = 0;
    err_bad = 0;
    got = 'x;
    accept(o, x, y);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (scramble && c == 6) begin
        a = ~x;
        b = y ^ 8'h5a;
        op = Operation'(o ^ 3'd1);
      end
      if (bus.nss !== ((c <= LAT - 1) ? sel_mask : idle_mask)) nss_bad++;
      if (ov === 1'b1) begin
        nvalid++;
        vcyc = c;
      end
      if (err !== 1'b0) err_bad++;
      if (c == LAT) got = res;
    end
    total++;
    if (nss_bad != 0) begin
      bad++;
      $display("FAIL %s_nss bad_cycles=%0d want=0", name, nss_bad);
    end
    total++;
    if (vcyc != LAT || nvalid != 1) begin
      bad++;
      $display("FAIL %s_latency got=%0d n=%0d want=%0d", name, vcyc, nvalid, LAT);
    end
    total++;
    if (got !== exp_res) begin
      bad++;
      $display("FAIL %s_result got=%0h want=%0h", name, got, exp_res);
    end
    total++;
    if (res !== exp_res) begin
      bad++;
      $display("FAIL %s_hold got=%0h want=%0h", name, res, exp_res);
    end
    total++;
    if (sl_pkt !== exp_pkt) begin
      bad++;
      $display("FAIL %s_packet got=%0h want=%0h", name, sl_pkt, exp_pkt);
    end
    total++;
    if (err_bad != 0) begin
      bad++;
      $display("FAIL %s_error got=%0d want=0", name, err_bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    op = OP_ADD;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({rdy, ov, err, res} !== {1'b1, 1'b0, 1'b0, {R{1'b0}}}) begin
      bad++;
      $display("FAIL reset_out got=%b want=%b", {rdy, ov, err, res},
               {1'b1, 1'b0, 1'b0, {R{1'b0}}});
    end
    total++;
    if (bus.nss !== idle_mask || bus.mosi !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus got=%b/%b want=%b/0", bus.nss, bus.mosi, idle_mask);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_op(3'd0, 8'd5, 8'd3, 1'b0, "add");
  endtask

  task automatic test_back_to_back();
    int vc[$];
    logic [R-1:0] vr[$];
    bit rdy1, rdy2;
    rdy1 = 1'b0;
    rdy2 = 1'b1;
    @(negedge clk);
    valid = 1'b1;
    op = OP_AND;
    a = 8'h0c;
    b = 8'h0a;
    @(posedge clk);
    #1 op = OP_OR;
    for (int c = 1; c <= 2 * LAT + 2; c++) begin
      @(negedge clk);
      if (ov === 1'b1) begin
        vc.push_back(c);
        vr.push_back(res);
      end
      if (c == LAT + 1) rdy1 = rdy;
      if (c == LAT + 2) begin
        rdy2 = rdy;
        valid = 1'b0;
      end
    end
    total++;
    if (rdy1 !== 1'b1 || rdy2 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept got=%b%b want=10", rdy1, rdy2);
    end
    total++;
    if (vc.size() != 2) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=2", vc.size());
    end else begin
      total++;
      if (vc[0] != LAT || vc[1] != 2 * LAT + 1) begin
        bad++;
        $display("FAIL b2b_cycles got=%0d,%0d want=%0d,%0d", vc[0], vc[1],
                 LAT, 2 * LAT + 1);
      end
      total++;
      if (vr[0] !== 8'h08 || vr[1] !== 8'h0e) begin
        bad++;
        $display("FAIL b2b_results got=%0h,%0h want=8,e", vr[0], vr[1]);
      end
    end
  endtask

  task automatic test_unsupported();
    run_op(3'd7, 8'h5c, 8'h33, 1'b0, "unsup");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++)
      run_op(3'($urandom_range(0, 4)), R'($urandom), R'($urandom), 1'b0, "rand");
  endtask

  task automatic test_scramble();
    run_op(3'd0, 8'h21, 8'h13, 1'b1, "latch");
  endtask

  task automatic test_timeout();
    logic [R-1:0] prev;
    int nerr, ecyc, vbad, nbad;
    nerr = 0;
    ecyc = -1;
    vbad = 0;
    nbad = 0;
    prev = res;
    slave_en = 1'b0;
    accept(3'd0, 8'd9, 8'd9);
    for (int c = 1; c <= P + 24; c++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        nerr++;
        ecyc = c;
      end
      if (ov !== 1'b0) vbad++;
      if (c >= P + 18 && bus.nss !== idle_mask) nbad++;
    end
    total++;
    if (nerr != 1 || ecyc != P + 2 + TO) begin
      bad++;
      $display("FAIL timeout_error got=%0d n=%0d want=%0d", ecyc, nerr, P + 2 + TO);
    end
    total++;
    if (vbad != 0 || res !== prev) begin
      bad++;
      $display("FAIL timeout_result got=%0h v=%0d want=%0h", res, vbad, prev);
    end
    total++;
    if (nbad != 0) begin
      bad++;
      $display("FAIL timeout_nss bad_cycles=%0d want=0", nbad);
    end
    slave_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    accept(3'd1, 8'h77, 8'h11);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rdy, ov, err, res} !== {1'b1, 1'b0, 1'b0, {R{1'b0}}}) begin
      bad++;
      $display("FAIL midreset_out got=%b want=%b", {rdy, ov, err, res},
               {1'b1, 1'b0, 1'b0, {R{1'b0}}});
    end
    total++;
    if (bus.nss !== idle_mask || bus.mosi !== 1'b0) begin
      bad++;
      $display("FAIL midreset_bus got=%b/%b want=%b/0", bus.nss, bus.mosi, idle_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 8'd1, 8'd1, 1'b0, "post_reset");
  endtask

  initial begin
    idle_mask = '1;
    sel_mask = ~(NW'(1) << POS);
    test_reset();
    test_add();
    test_back_to_back();
    test_unsupported();
    test_random();
    test_scramble();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
